// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP multi-cycle control unit:
//   - 4-bit opcode values (OP_HLT .. OP_NOP); anything else is illegal
//   - accumulator input mux encodings (SELA_*)
//   - control FSM state encoding
//   - small decode helpers used by the control unit
// -----------------------------------------------------------------------------
package bip_pkg;

    // Opcode field width that carries the defined instruction set. Wider
    // OpCode buses must have all bits above this range at zero to be legal.
    localparam int unsigned OP_BITS = 4;

    typedef logic [OP_BITS-1:0] op_t;

    localparam op_t OP_HLT  = 4'd0;
    localparam op_t OP_STO  = 4'd1;
    localparam op_t OP_LD   = 4'd2;
    localparam op_t OP_LDI  = 4'd3;
    localparam op_t OP_ADD  = 4'd4;
    localparam op_t OP_ADDI = 4'd5;
    localparam op_t OP_SUB  = 4'd6;
    localparam op_t OP_SUBI = 4'd7;
    localparam op_t OP_BEQ  = 4'd8;
    localparam op_t OP_BNE  = 4'd9;
    localparam op_t OP_BPL  = 4'd10;
    localparam op_t OP_BMI  = 4'd11;
    localparam op_t OP_JMP  = 4'd12;
    localparam op_t OP_NOP  = 4'd13;

    // Accumulator input mux select encodings.
    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Instructions that need the extra MEM cycle for synchronous RAM read data.
    function automatic logic is_mem_op(input op_t op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Branch condition evaluation from the accumulator flags.
    function automatic logic branch_taken(input op_t op, input logic acc_zero,
                                          input logic acc_neg);
        logic taken;
        case (op)
            OP_BEQ:  taken = acc_zero;
            OP_BNE:  taken = !acc_zero;
            OP_BPL:  taken = !acc_neg;
            OP_BMI:  taken = acc_neg;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/bip_pc_reg.sv
// -----------------------------------------------------------------------------
// bip_pc_reg
// Program counter register. Reset loads RESET_PC; otherwise a load takes the
// branch target, an advance increments modulo 2^PC_WIDTH, else it holds.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   load     in   take target this edge (priority over advance)
//   advance  in   increment this edge
//   target   in   [PC_WIDTH] branch target
//   pc       out  [PC_WIDTH] registered PC
// -----------------------------------------------------------------------------
module bip_pc_reg #(
    parameter int unsigned          PC_WIDTH = 11,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                advance,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;

    always_comb begin
        // NOTE: assign a default before any branch so every path writes pc_d;
        // a missing assignment would infer a latch.
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (advance) begin
            // Natural overflow of the PC_WIDTH-bit add gives the wrap to 0.
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
// Multi-cycle control unit for the BIP processor. Sequences each instruction
// through FETCH -> EXEC (-> MEM) and owns the program counter. Supports
// conditional/unconditional branches, a latched HALT state and illegal-opcode
// flagging. Strobes are combinational from the state and OpCode (EXEC) or the
// latched opcode op_q (MEM).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   OpCode, Operand  instruction fields from program memory (valid in EXEC)
//   AccZero, AccNeg  accumulator flags, sampled in EXEC
//   address_output   program-memory address (registered PC)
//   SelA, SelB       accumulator input mux / ALU B operand selects
//   WrAcc, Op        accumulator write enable / ALU add(0)-sub(1)
//   WrRam, RdRam     data RAM write / read enables
//   halted           high while in HALT
//   illegal          one-cycle pulse in EXEC of an undefined opcode
// -----------------------------------------------------------------------------
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int unsigned          PC_WIDTH      = 11,
    parameter int unsigned          OPCODE_WIDTH  = 5,
    parameter int unsigned          OPERAND_WIDTH = 11,
    parameter logic [PC_WIDTH-1:0]  RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPCODE_WIDTH-1:0]  OpCode,
    input  logic [OPERAND_WIDTH-1:0] Operand,
    input  logic                     AccZero,
    input  logic                     AccNeg,
    output logic [PC_WIDTH-1:0]      address_output,
    output logic [1:0]               SelA,
    output logic                     SelB,
    output logic                     WrAcc,
    output logic                     Op,
    output logic                     WrRam,
    output logic                     RdRam,
    output logic                     halted,
    output logic                     illegal
);

    state_e state_d, state_q;
    op_t    op_d, op_q;

    op_t    op_lo;
    logic   op_legal;
    logic   pc_load;
    logic   pc_advance;

    // Opcodes are legal only when every bit above the 4-bit field is zero and
    // the low field falls inside the defined range.
    assign op_lo    = OpCode[OP_BITS-1:0];
    assign op_legal = ((OpCode >> OP_BITS) == '0) && (op_lo <= OP_NOP);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_load    = 1'b0;
        pc_advance = 1'b0;
        SelA       = SELA_RAM;
        SelB       = 1'b0;
        WrAcc      = 1'b0;
        Op         = 1'b0;
        WrRam      = 1'b0;
        RdRam      = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                op_d       = op_lo;
                state_d    = ST_FETCH;
                pc_advance = 1'b1;
                if (!op_legal) begin
                    illegal = 1'b1;
                end else begin
                    case (op_lo)
                        OP_HLT: begin
                            state_d    = ST_HALT;
                            pc_advance = 1'b0;
                        end
                        OP_STO: WrRam = 1'b1;
                        OP_LD, OP_ADD, OP_SUB: begin
                            RdRam   = 1'b1;
                            state_d = ST_MEM;
                        end
                        OP_LDI: begin
                            SelA  = SELA_IMM;
                            WrAcc = 1'b1;
                        end
                        OP_ADDI, OP_SUBI: begin
                            SelB  = 1'b1;
                            SelA  = SELA_ALU;
                            WrAcc = 1'b1;
                            Op    = (op_lo == OP_SUBI);
                        end
                        OP_BEQ, OP_BNE, OP_BPL, OP_BMI, OP_JMP: begin
                            pc_load = branch_taken(op_lo, AccZero, AccNeg);
                        end
                        default: ;
                    endcase
                end
            end

            ST_MEM: begin
                // RAM data requested in EXEC arrives now; decode the latched
                // opcode because program memory has moved on.
                state_d = ST_FETCH;
                if (is_mem_op(op_q)) begin
                    WrAcc = 1'b1;
                    if (op_q != OP_LD) begin
                        SelA = SELA_ALU;
                        Op   = (op_q == OP_SUB);
                    end
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    bip_pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .advance (pc_advance),
        .target  (PC_WIDTH'(Operand)),
        .pc      (address_output)
    );

endmodule
